sata_link_layer_write: RTL and testbench
========================================

Name: sata_link_layer_write

Overview:
- Transmit half of the SATA link layer: turns a transport-layer dword stream into a link frame X_RDY, SOF, scrambled data, scrambled CRC, EOF, WTRM, then waits for the remote R_OK or R_ERR.
- Peer of the link read path. Shares the phy-facing primitive detect inputs, and the top-level link mux selects its tx_dout/tx_is_k whenever it is not idle.
- Instantiates the codebase crc and scrambler blocks.

Parameters:
- COUNT_WIDTH, 14: width of write_count. Maximum frame is 2^COUNT_WIDTH-1 dwords.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- phy_ready  in  1  phy can accept a dword this cycle; when low (ALIGN slot) no state, strobe or counter advances
- en  in  1  block may leave IDLE
- idle  out  1  state==IDLE
- sync_escape  in  1  transport abort request
- is_device  in  1  1=device role (loses X_RDY collision)
- data_scrambler_en  in  1  scramble data and CRC dwords
- detect_sync, detect_r_rdy, detect_r_ip, detect_r_ok, detect_r_err, detect_hold, detect_holda, detect_x_rdy  in  1 each  primitive detects from the rx path
- write_start  in  1  pulse: frame of write_count dwords is queued
- write_count  in  COUNT_WIDTH  dword count, sampled on write_start
- write_data  in  32  current dword from the source
- write_data_ready  in  1  write_data valid
- write_strobe  out  1  write_data consumed this cycle; source advances next cycle
- write_finished  out  1  one-cycle pulse at frame completion
- xmit_ok  out  1  one-cycle pulse: remote sent R_OK
- xmit_err  out  1  one-cycle pulse: remote sent R_ERR
- remote_abort  out  1  one-cycle pulse: SYNC received mid-frame
- xrdy_collision  out  1  one-cycle pulse: device backed off on X_RDY/X_RDY
- tx_dout  out  32  dword to phy
- tx_is_k  out  1  tx_dout is a primitive
- lax_w_state  out  4  state, for debug

Behaviour:
- Reset (async, rst_n low): state=IDLE, all pulses 0, tx_dout=PRIM_SYNC, tx_is_k=1, the counter is cleared, and the crc and scrambler are reset. They are also held in reset while idle.
- States:
  - IDLE=0: tx SYNC. On write_start && en && phy_ready, latch write_count and go to SEND_XRDY. If write_count==0, pulse write_finished and stay in IDLE.
  - SEND_XRDY=1: tx X_RDY.
    - detect_r_rdy goes to SEND_SOF.
    - detect_x_rdy && is_device pulses xrdy_collision and goes to IDLE; the frame stays pending, so the source must reissue write_start.
    - detect_x_rdy && !is_device keeps sending X_RDY.
  - SEND_SOF=2: tx SOF for one phy_ready cycle, then go to SEND_DATA.
  - SEND_DATA=3, per phy_ready cycle, in priority order:
    - detect_hold: tx HOLDA, no strobe.
    - !write_data_ready: tx HOLD, no strobe.
    - Otherwise: tx scrambler(write_data) (or raw write_data when the scrambler is disabled), tx_is_k=0, assert write_strobe, feed write_data (unscrambled) to the crc, and decrement the counter. When the counter reaches 0, go to SEND_CRC.
  - SEND_CRC=4: tx the crc dout, scrambled with the next scrambler word when enabled; tx_is_k=0. Go to SEND_EOF.
  - SEND_EOF=5: tx EOF, go to WAIT_STATUS.
  - WAIT_STATUS=6: tx WTRM.
    - detect_r_ok: pulse xmit_ok and write_finished, go to SEND_SYNC.
    - detect_r_err: pulse xmit_err and write_finished, go to SEND_SYNC.
  - SEND_SYNC=7: tx SYNC until detect_sync, then go to IDLE.
- Global, highest priority, in any state other than IDLE and SEND_SYNC:
  - sync_escape: tx SYNC, go to SEND_SYNC, no further strobes.
  - Otherwise detect_sync: pulse remote_abort, go to IDLE.
- phy_ready low:
  - tx_dout/tx_is_k hold their previous value; the phy inserts ALIGN.
  - No write_strobe, no crc or scrambler enable, no transition. The global aborts above still apply.
- Latency: tx_dout is registered, one cycle after the decision. write_strobe is coincident with the cycle the dword is captured into the tx register.
- CRC: seed 0x52325032 per the crc block, over unscrambled data only. The scrambler advances on every data dword and on the CRC dword, never on primitives.
- The block sends repeated primitives as-is; CONT insertion is downstream.

Decomposition:
- Shared sata_defines.v: PRIM_* constants, including X_RDY, SOF, EOF, WTRM, HOLD, HOLDA and SYNC, plus the state encodings above.
- Sub-modules: the existing crc and scrambler (prim_scrambler=0). No new sub-module.

Test Plan:
- 4-dword frame, data 0x1,0x2,0x3,0x4, scrambler off, remote sends R_RDY then R_OK → tx X_RDY…, SOF, 4 data dwords with tx_is_k=0, CRC dword equal to the reference CRC, EOF, WTRM…; xmit_ok and write_finished pulse once; 4 write_strobes.
- Same frame with the scrambler on → on-wire data equals reference LFSR XOR data; a loopback into the read path reports crc_ok=1.
- write_data_ready low for 3 cycles mid-frame → exactly 3 HOLD dwords, no strobes, data order preserved. detect_hold for 2 cycles → 2 HOLDA dwords.
- phy_ready low every 4th cycle over a 16-dword frame → exactly 16 strobes, identical on-wire sequence ignoring stalls.
- is_device=1 with X_RDY received in SEND_XRDY → xrdy_collision pulse, IDLE. With is_device=0 → X_RDY continues.
- detect_sync during SEND_DATA → remote_abort pulse, IDLE next cycle. sync_escape → SYNC until detect_sync. rst_n low mid-frame → immediate SYNC/IDLE with outputs at reset values.

Source files
------------

// File: rtl/sata_link_layer_write_pkg.sv
// Shared definitions for the SATA link-layer transmit (write) path.
// Contents: primitive dword encodings, state encodings, CRC/scrambler
// constants and the helper functions that advance the CRC and the scrambler.
package sata_link_layer_write_pkg;

    // Primitive dwords (K28.3/K28.5 lead byte in bits [7:0])
    localparam logic [31:0] PRIM_ALIGN = 32'h7B4A_4ABC;
    localparam logic [31:0] PRIM_SYNC  = 32'hB5B5_957C;
    localparam logic [31:0] PRIM_X_RDY = 32'h5757_B57C;
    localparam logic [31:0] PRIM_R_RDY = 32'h4A4A_957C;
    localparam logic [31:0] PRIM_SOF   = 32'h3737_B57C;
    localparam logic [31:0] PRIM_EOF   = 32'hD5D5_B57C;
    localparam logic [31:0] PRIM_WTRM  = 32'h5858_B57C;
    localparam logic [31:0] PRIM_HOLD  = 32'hD5D5_AA7C;
    localparam logic [31:0] PRIM_HOLDA = 32'h9595_AA7C;
    localparam logic [31:0] PRIM_R_OK  = 32'h3535_B57C;
    localparam logic [31:0] PRIM_R_ERR = 32'h5656_B57C;

    // Frame CRC: non-reflected CRC-32, no final inversion
    localparam logic [31:0] CRC_SEED = 32'h5232_5032;
    localparam logic [31:0] CRC_POLY = 32'h04C1_1DB7;

    // Scrambler LFSR x^16+x^15+x^13+x^4+1
    localparam logic [15:0] SCR_SEED = 16'hFFFF;

    typedef enum logic [3:0] {
        ST_IDLE        = 4'd0,
        ST_SEND_XRDY   = 4'd1,
        ST_SEND_SOF    = 4'd2,
        ST_SEND_DATA   = 4'd3,
        ST_SEND_CRC    = 4'd4,
        ST_SEND_EOF    = 4'd5,
        ST_WAIT_STATUS = 4'd6,
        ST_SEND_SYNC   = 4'd7
    } lw_state_e;

    // Fold one dword into the CRC, MSB first
    function automatic logic [31:0] crc_step(input logic [31:0] crc, input logic [31:0] din);
        logic [31:0] c;
        c = crc ^ din;
        for (int k = 0; k < 32; k++) begin
            if (c[31]) begin
                c = {c[30:0], 1'b0} ^ CRC_POLY;
            end else begin
                c = {c[30:0], 1'b0};
            end
        end
        return c;
    endfunction

    // 32 scrambler bits from the current LFSR state; first bit lands in bit 31
    function automatic logic [31:0] scr_word(input logic [15:0] st);
        logic [15:0] r;
        logic [31:0] w;
        r = st;
        w = 32'h0000_0000;
        for (int k = 0; k < 32; k++) begin
            w[31-k] = r[15];
            r = {r[14:0], r[15] ^ r[14] ^ r[12] ^ r[3]};
        end
        return w;
    endfunction

    // LFSR state after producing one 32-bit word
    function automatic logic [15:0] scr_next(input logic [15:0] st);
        logic [15:0] r;
        r = st;
        for (int k = 0; k < 32; k++) begin
            r = {r[14:0], r[15] ^ r[14] ^ r[12] ^ r[3]};
        end
        return r;
    endfunction

endpackage

// File: rtl/sata_link_layer_write_if.sv
// Transport-side handshake between a dword source (master) and the link
// write path (slave): frame request, data stream with strobe, and the
// one-cycle completion/status pulses returned to the transport layer.
interface sata_link_layer_write_if #(
    parameter int COUNT_WIDTH = 14
);
    logic                   write_start;
    logic [COUNT_WIDTH-1:0] write_count;
    logic [31:0]            write_data;
    logic                   write_data_ready;
    logic                   write_strobe;
    logic                   write_finished;
    logic                   xmit_ok;
    logic                   xmit_err;
    logic                   remote_abort;
    logic                   xrdy_collision;

    modport master (
        output write_start, write_count, write_data, write_data_ready,
        input  write_strobe, write_finished, xmit_ok, xmit_err,
               remote_abort, xrdy_collision
    );

    modport slave (
        input  write_start, write_count, write_data, write_data_ready,
        output write_strobe, write_finished, xmit_ok, xmit_err,
               remote_abort, xrdy_collision
    );
endinterface

// File: rtl/sata_link_layer_write_lfsr.sv
// Frame CRC generator and data scrambler for the link write path.
// Ports: clk, rst_n (async), srst (sync, held while the link is idle),
// crc_en/crc_din fold an unscrambled dword into the CRC, scr_en advances
// the scrambler by one word, crc_dout is the running CRC, scr_dout the
// scrambler word to XOR onto the next data/CRC dword.
module sata_link_layer_write_lfsr
    import sata_link_layer_write_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        srst,
    input  logic        crc_en,
    input  logic [31:0] crc_din,
    input  logic        scr_en,
    output logic [31:0] crc_dout,
    output logic [31:0] scr_dout
);

    logic [31:0] crc_r;
    logic [15:0] scr_r;

    // Running CRC over the unscrambled payload
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_r <= CRC_SEED;
        end else if (srst) begin
            crc_r <= CRC_SEED;
        end else if (crc_en) begin
            crc_r <= crc_step(crc_r, crc_din);
        end else begin
            crc_r <= crc_r;
        end
    end

    // Scrambler state, one step per data or CRC dword
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scr_r <= SCR_SEED;
        end else if (srst) begin
            scr_r <= SCR_SEED;
        end else if (scr_en) begin
            scr_r <= scr_next(scr_r);
        end else begin
            scr_r <= scr_r;
        end
    end

    assign crc_dout = crc_r;
    assign scr_dout = scr_word(scr_r);

endmodule

// File: rtl/sata_link_layer_write.sv
// SATA link layer, transmit half. Turns a transport dword stream into
// X_RDY, SOF, (scrambled) data, (scrambled) CRC, EOF, WTRM and waits for
// R_OK/R_ERR from the remote end.
// Ports: clk/rst_n; phy_ready (ALIGN slot when low); en gates leaving IDLE;
// sync_escape transport abort; is_device role; data_scrambler_en;
// detect_* primitive detects from the rx path; wr = transport handshake
// (slave side); tx_dout/tx_is_k registered dword to phy; idle and
// lax_w_state for the link mux and debug.
module sata_link_layer_write
    import sata_link_layer_write_pkg::*;
#(
    parameter int COUNT_WIDTH = 14
)
(
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          phy_ready,
    input  logic                          en,
    output logic                          idle,
    input  logic                          sync_escape,
    input  logic                          is_device,
    input  logic                          data_scrambler_en,
    input  logic                          detect_sync,
    input  logic                          detect_r_rdy,
    input  logic                          detect_r_ip,
    input  logic                          detect_r_ok,
    input  logic                          detect_r_err,
    input  logic                          detect_hold,
    input  logic                          detect_holda,
    input  logic                          detect_x_rdy,
    sata_link_layer_write_if.slave        wr,
    output logic [31:0]                   tx_dout,
    output logic                          tx_is_k,
    output logic [3:0]                    lax_w_state
);

    localparam logic [COUNT_WIDTH-1:0] CNT_ZERO = {COUNT_WIDTH{1'b0}};
    localparam logic [COUNT_WIDTH-1:0] CNT_ONE  = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

    lw_state_e              state_r, state_s;
    logic [COUNT_WIDTH-1:0] count_r, count_s;
    logic [31:0]            tx_dout_r, tx_dout_s;
    logic                   tx_is_k_r, tx_is_k_s;
    logic                   finished_r, finished_s;
    logic                   ok_r, ok_s;
    logic                   err_r, err_s;
    logic                   abort_r, abort_s;
    logic                   coll_r, coll_s;
    logic                   strobe_s, crc_en_s, scr_en_s;
    logic                   abortable_s;
    logic [31:0]            crc_dout_s, scr_dout_s, data_word_s, crc_word_s;
    logic                   unused_s;

    // R_IP and HOLDA from the remote need no action on the transmit side
    assign unused_s = detect_r_ip ^ detect_holda;

    sata_link_layer_write_lfsr u_lfsr (
        .clk      (clk),
        .rst_n    (rst_n),
        .srst     (state_r == ST_IDLE),
        .crc_en   (crc_en_s),
        .crc_din  (wr.write_data),
        .scr_en   (scr_en_s),
        .crc_dout (crc_dout_s),
        .scr_dout (scr_dout_s)
    );

    assign data_word_s = data_scrambler_en ? (wr.write_data ^ scr_dout_s) : wr.write_data;
    assign crc_word_s  = data_scrambler_en ? (crc_dout_s ^ scr_dout_s)    : crc_dout_s;
    assign abortable_s = (state_r != ST_IDLE) && (state_r != ST_SEND_SYNC);

    // Next state, next tx dword and per-cycle strobes
    always_comb begin
        state_s    = state_r;
        count_s    = count_r;
        tx_dout_s  = tx_dout_r;
        tx_is_k_s  = tx_is_k_r;
        finished_s = 1'b0;
        ok_s       = 1'b0;
        err_s      = 1'b0;
        abort_s    = 1'b0;
        coll_s     = 1'b0;
        strobe_s   = 1'b0;
        crc_en_s   = 1'b0;
        scr_en_s   = 1'b0;

        // Aborts act even in an ALIGN slot; the tx register only moves when the phy takes a dword
        if (abortable_s && sync_escape) begin
            state_s = ST_SEND_SYNC;
            if (phy_ready) begin
                tx_dout_s = PRIM_SYNC;
                tx_is_k_s = 1'b1;
            end else begin
                tx_dout_s = tx_dout_r;
            end
        end else if (abortable_s && detect_sync) begin
            abort_s = 1'b1;
            state_s = ST_IDLE;
            if (phy_ready) begin
                tx_dout_s = PRIM_SYNC;
                tx_is_k_s = 1'b1;
            end else begin
                tx_dout_s = tx_dout_r;
            end
        end else if (phy_ready) begin
            tx_is_k_s = 1'b1;
            case (state_r)
                ST_IDLE: begin
                    tx_dout_s = PRIM_SYNC;
                    if (wr.write_start && en) begin
                        if (wr.write_count == CNT_ZERO) begin
                            finished_s = 1'b1;
                        end else begin
                            count_s = wr.write_count;
                            state_s = ST_SEND_XRDY;
                        end
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_SEND_XRDY: begin
                    tx_dout_s = PRIM_X_RDY;
                    if (detect_r_rdy) begin
                        state_s = ST_SEND_SOF;
                    end else if (detect_x_rdy && is_device) begin
                        // Device yields to the host; source must re-request the frame
                        coll_s    = 1'b1;
                        state_s   = ST_IDLE;
                        tx_dout_s = PRIM_SYNC;
                    end else begin
                        state_s = ST_SEND_XRDY;
                    end
                end
                ST_SEND_SOF: begin
                    tx_dout_s = PRIM_SOF;
                    state_s   = ST_SEND_DATA;
                end
                ST_SEND_DATA: begin
                    if (detect_hold) begin
                        tx_dout_s = PRIM_HOLDA;
                    end else if (!wr.write_data_ready) begin
                        tx_dout_s = PRIM_HOLD;
                    end else begin
                        tx_dout_s = data_word_s;
                        tx_is_k_s = 1'b0;
                        strobe_s  = 1'b1;
                        crc_en_s  = 1'b1;
                        scr_en_s  = 1'b1;
                        count_s   = count_r - CNT_ONE;
                        if (count_r == CNT_ONE) begin
                            state_s = ST_SEND_CRC;
                        end else begin
                            state_s = ST_SEND_DATA;
                        end
                    end
                end
                ST_SEND_CRC: begin
                    tx_dout_s = crc_word_s;
                    tx_is_k_s = 1'b0;
                    scr_en_s  = 1'b1;
                    state_s   = ST_SEND_EOF;
                end
                ST_SEND_EOF: begin
                    tx_dout_s = PRIM_EOF;
                    state_s   = ST_WAIT_STATUS;
                end
                ST_WAIT_STATUS: begin
                    tx_dout_s = PRIM_WTRM;
                    if (detect_r_ok) begin
                        ok_s       = 1'b1;
                        finished_s = 1'b1;
                        state_s    = ST_SEND_SYNC;
                        tx_dout_s  = PRIM_SYNC;
                    end else if (detect_r_err) begin
                        err_s      = 1'b1;
                        finished_s = 1'b1;
                        state_s    = ST_SEND_SYNC;
                        tx_dout_s  = PRIM_SYNC;
                    end else begin
                        state_s = ST_WAIT_STATUS;
                    end
                end
                ST_SEND_SYNC: begin
                    tx_dout_s = PRIM_SYNC;
                    if (detect_sync) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_SEND_SYNC;
                    end
                end
                default: begin
                    tx_dout_s = PRIM_SYNC;
                    state_s   = ST_IDLE;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // State, counter, tx dword and status pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            count_r    <= CNT_ZERO;
            tx_dout_r  <= PRIM_SYNC;
            tx_is_k_r  <= 1'b1;
            finished_r <= 1'b0;
            ok_r       <= 1'b0;
            err_r      <= 1'b0;
            abort_r    <= 1'b0;
            coll_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            count_r    <= count_s;
            tx_dout_r  <= tx_dout_s;
            tx_is_k_r  <= tx_is_k_s;
            finished_r <= finished_s;
            ok_r       <= ok_s;
            err_r      <= err_s;
            abort_r    <= abort_s;
            coll_r     <= coll_s;
        end
    end

    assign idle              = (state_r == ST_IDLE);
    assign lax_w_state       = state_r;
    assign tx_dout           = tx_dout_r;
    assign tx_is_k           = tx_is_k_r;
    assign wr.write_strobe   = strobe_s;
    assign wr.write_finished = finished_r;
    assign wr.xmit_ok        = ok_r;
    assign wr.xmit_err       = err_r;
    assign wr.remote_abort   = abort_r;
    assign wr.xrdy_collision = coll_r;

endmodule

// File: tb/tb_sata_link_layer_write.sv
// Randomized self-checking bench for sata_link_layer_write. A reactive
// remote answers X_RDY/WTRM/SYNC; a frame-level reference computes the
// expected on-wire payload (bit-serial CRC and bit-sequence scrambler).
module tb_sata_link_layer_write;

    localparam int CW = 14;
    localparam logic [31:0] P_SYNC  = 32'hB5B5_957C;
    localparam logic [31:0] P_XRDY  = 32'h5757_B57C;
    localparam logic [31:0] P_SOF   = 32'h3737_B57C;
    localparam logic [31:0] P_EOF   = 32'hD5D5_B57C;
    localparam logic [31:0] P_WTRM  = 32'h5858_B57C;
    localparam logic [31:0] P_HOLD  = 32'hD5D5_AA7C;
    localparam logic [31:0] P_HOLDA = 32'h9595_AA7C;
    localparam logic [31:0] R_POLY  = 32'h04C1_1DB7;
    localparam logic [31:0] R_SEED  = 32'h5232_5032;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic phy_ready = 1'b0, en = 1'b0, sync_escape = 1'b0, is_device = 1'b0;
    logic data_scrambler_en = 1'b0;
    logic detect_sync = 1'b0, detect_r_rdy = 1'b0, detect_r_ip = 1'b0, detect_r_ok = 1'b0;
    logic detect_r_err = 1'b0, detect_hold = 1'b0, detect_holda = 1'b0, detect_x_rdy = 1'b0;
    logic idle, tx_is_k;
    logic [31:0] tx_dout;
    logic [3:0] lax_w_state;

    sata_link_layer_write_if #(.COUNT_WIDTH(CW)) wr();

    sata_link_layer_write #(.COUNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .phy_ready(phy_ready), .en(en), .idle(idle),
        .sync_escape(sync_escape), .is_device(is_device), .data_scrambler_en(data_scrambler_en),
        .detect_sync(detect_sync), .detect_r_rdy(detect_r_rdy), .detect_r_ip(detect_r_ip),
        .detect_r_ok(detect_r_ok), .detect_r_err(detect_r_err), .detect_hold(detect_hold),
        .detect_holda(detect_holda), .detect_x_rdy(detect_x_rdy), .wr(wr),
        .tx_dout(tx_dout), .tx_is_k(tx_is_k), .lax_w_state(lax_w_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    int strobes, fin_cnt, ok_cnt, err_cnt, abort_cnt, coll_cnt, cyc, src_idx;
    bit capture_on, prev_pr;
    logic [31:0] wire_d[$];
    logic        wire_k[$];
    logic [31:0] src_q[$];
    bit scr_bits [0:2047];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference CRC: polynomial division, one payload bit at a time
    function automatic logic [31:0] ref_crc(input logic [31:0] d[$]);
        logic [31:0] c;
        logic fb;
        c = R_SEED;
        foreach (d[i]) begin
            for (int b = 31; b >= 0; b--) begin
                fb = c[31] ^ d[i][b];
                c = c << 1;
                if (fb) c = c ^ R_POLY;
            end
        end
        return c;
    endfunction

    // Scrambler word j taken from the precomputed LFSR bit sequence
    function automatic logic [31:0] ref_scr(input int j);
        logic [31:0] w;
        for (int b = 0; b < 32; b++) w[31-b] = scr_bits[32*j+b];
        return w;
    endfunction

    task automatic clear_counts();
        strobes = 0; fin_cnt = 0; ok_cnt = 0; err_cnt = 0; abort_cnt = 0; coll_cnt = 0;
        wire_d.delete(); wire_k.delete();
    endtask

    // Inputs are set; let one clock edge pass and observe at the following negedge
    task automatic tick();
        logic strobe_seen;
        #1;
        strobe_seen = wr.write_strobe;
        if (strobe_seen) strobes++;
        prev_pr = phy_ready;
        @(negedge clk);
        if (capture_on && prev_pr) begin
            wire_d.push_back(tx_dout);
            wire_k.push_back(tx_is_k);
        end
        if (wr.write_finished) fin_cnt++;
        if (wr.xmit_ok) ok_cnt++;
        if (wr.xmit_err) err_cnt++;
        if (wr.remote_abort) abort_cnt++;
        if (wr.xrdy_collision) coll_cnt++;
        if (strobe_seen) src_idx++;
        wr.write_data = (src_idx < src_q.size()) ? src_q[src_idx] : $urandom();
        cyc++;
    endtask

    task automatic issue_start(input int n);
        src_idx = 0;
        wr.write_data = (src_q.size() > 0) ? src_q[0] : 32'h0000_0000;
        wr.write_count = CW'(n);
        wr.write_start = 1'b1;
        phy_ready = 1'b1;
        tick();
        wr.write_start = 1'b0;
    endtask

    task automatic run_frame(input int n, input bit scr, input int pr_mode, input bit noisy,
                             input bit want_err, input bit allow_xrdy, input bit fixed);
        logic [31:0] exp_w[$];
        logic [63:0] shape, exp_shape;
        logic [7:0] t, last_t;
        int exp_hold, exp_holda, exp_str, n_hold, n_holda, di;
        bit sof_seen, status_done, done;
        src_q.delete();
        for (int i = 0; i < n; i++) src_q.push_back(fixed ? 32'(i + 1) : $urandom());
        for (int i = 0; i < n; i++) exp_w.push_back(src_q[i] ^ (scr ? ref_scr(i) : 32'h0));
        exp_w.push_back(ref_crc(src_q) ^ (scr ? ref_scr(n) : 32'h0));
        clear_counts();
        data_scrambler_en = scr;
        is_device = 1'b0;
        exp_hold = 0; exp_holda = 0; exp_str = 0;
        sof_seen = 1'b0; status_done = 1'b0; done = 1'b0;
        capture_on = 1'b1;
        issue_start(n);
        for (int c = 0; c < 3000 && !done; c++) begin
            if (tx_dout == P_SOF && tx_is_k) sof_seen = 1'b1;
            status_done = (ok_cnt + err_cnt) > 0;
            case (pr_mode)
                0: phy_ready = 1'b1;
                1: phy_ready = ($urandom_range(0, 4) != 0);
                default: phy_ready = ((cyc % 4) != 3);
            endcase
            detect_r_rdy = (tx_dout == P_XRDY) && ($urandom_range(0, 2) == 0);
            detect_x_rdy = allow_xrdy && (tx_dout == P_XRDY) && $urandom_range(0, 1);
            detect_r_ok  = !want_err && !status_done && (tx_dout == P_WTRM) && $urandom_range(0, 1);
            detect_r_err =  want_err && !status_done && (tx_dout == P_WTRM) && $urandom_range(0, 1);
            detect_sync  = status_done && (tx_dout == P_SYNC) && $urandom_range(0, 1);
            wr.write_data_ready = noisy ? ($urandom_range(0, 3) != 0) : 1'b1;
            detect_hold = noisy && sof_seen && ($urandom_range(0, 4) == 0);
            if (sof_seen && exp_str < n && phy_ready) begin
                if (detect_hold) exp_holda++;
                else if (!wr.write_data_ready) exp_hold++;
                else exp_str++;
            end
            tick();
            done = ((ok_cnt + err_cnt) > 0) && idle;
        end
        {detect_r_rdy, detect_x_rdy, detect_r_ok, detect_r_err, detect_sync, detect_hold} = 6'b0;
        capture_on = 1'b0;
        check_eq("frame_done", done, 1);
        check_eq("strobes", strobes, n);
        check_eq("finished", fin_cnt, 1);
        check_eq("xmit_ok", ok_cnt, want_err ? 0 : 1);
        check_eq("xmit_err", err_cnt, want_err ? 1 : 0);
        check_eq("no_abort", abort_cnt + coll_cnt, 0);
        shape = 64'h0; last_t = 8'h00; n_hold = 0; n_holda = 0; di = 0;
        foreach (wire_d[i]) begin
            if (!wire_k[i]) begin
                t = "D";
                if (di <= n) check_eq("data", wire_d[i], exp_w[di]);
                di++;
            end else if (wire_d[i] == P_HOLD) begin
                t = 8'h00; n_hold++;
            end else if (wire_d[i] == P_HOLDA) begin
                t = 8'h00; n_holda++;
            end else begin
                case (wire_d[i])
                    P_SYNC:  t = "S";
                    P_XRDY:  t = "X";
                    P_SOF:   t = "O";
                    P_EOF:   t = "E";
                    P_WTRM:  t = "W";
                    default: t = "?";
                endcase
            end
            if (t != 8'h00 && t != last_t) begin
                shape = {shape[55:0], t};
                last_t = t;
            end
        end
        exp_shape = {8'h00, "SXODEWS"};
        check_eq("data_words", di, n + 1);
        check_eq("frame_shape", shape, exp_shape);
        check_eq("hold_count", n_hold, exp_hold);
        check_eq("holda_count", n_holda, exp_holda);
    endtask

    // Start a frame with an eager remote and stop after two payload dwords
    task automatic start_to_data(input int n);
        bit reached;
        src_q.delete();
        for (int i = 0; i < n; i++) src_q.push_back($urandom());
        clear_counts();
        issue_start(n);
        wr.write_data_ready = 1'b1;
        reached = 1'b0;
        for (int c = 0; c < 100 && !reached; c++) begin
            detect_r_rdy = (tx_dout == P_XRDY);
            tick();
            reached = strobes >= 2;
        end
        detect_r_rdy = 1'b0;
        check_eq("reach_data", reached, 1);
    endtask

    initial begin
        bit seen;
        for (int k = 0; k < 16; k++) scr_bits[k] = 1'b1;
        for (int k = 16; k < 2048; k++)
            scr_bits[k] = scr_bits[k-16] ^ scr_bits[k-15] ^ scr_bits[k-13] ^ scr_bits[k-4];
        wr.write_start = 1'b0; wr.write_count = '0; wr.write_data = 32'h0; wr.write_data_ready = 1'b0;
        cyc = 0; capture_on = 1'b0; src_idx = 0;
        clear_counts();
        repeat (2) @(negedge clk);
        check_eq("rst_tx", tx_dout, P_SYNC);
        check_eq("rst_k", tx_is_k, 1);
        check_eq("rst_idle", idle, 1);
        check_eq("rst_state", lax_w_state, 0);
        check_eq("rst_pulses", {wr.write_finished, wr.xmit_ok, wr.xmit_err, wr.remote_abort, wr.xrdy_collision}, 0);
        rst_n = 1'b1; en = 1'b1;
        @(negedge clk);

        // Zero-length request completes at once
        clear_counts(); src_q.delete(); capture_on = 1'b1;
        issue_start(0);
        capture_on = 1'b0;
        check_eq("zero_finished", fin_cnt, 1);
        check_eq("zero_idle", idle, 1);
        check_eq("zero_tx", tx_dout, P_SYNC);

        run_frame(4, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        run_frame(4, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        run_frame(16, 1'b1, 2, 1'b0, 1'b0, 1'b0, 1'b0);
        run_frame(12, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++)
            run_frame($urandom_range(1, 20), 1'($urandom_range(0, 1)), $urandom_range(0, 2),
                      1'b1, (i % 3) == 2, 1'(i % 2), 1'b0);

        // Device loses the X_RDY collision
        is_device = 1'b1;
        src_q.delete(); src_q.push_back(32'h1); src_q.push_back(32'h2); src_q.push_back(32'h3);
        clear_counts();
        issue_start(3);
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            seen = (tx_dout == P_XRDY);
            if (!seen) tick();
        end
        detect_x_rdy = 1'b1;
        tick();
        detect_x_rdy = 1'b0;
        check_eq("coll_seen_xrdy", seen, 1);
        check_eq("coll_pulse", coll_cnt, 1);
        check_eq("coll_idle", idle, 1);
        check_eq("coll_tx", tx_dout, P_SYNC);
        is_device = 1'b0;
        run_frame(3, 1'b1, 1, 1'b1, 1'b0, 1'b0, 1'b0);

        // Remote SYNC mid-frame
        start_to_data(8);
        detect_sync = 1'b1;
        tick();
        detect_sync = 1'b0;
        check_eq("abort_pulse", abort_cnt, 1);
        check_eq("abort_idle", idle, 1);
        check_eq("abort_tx", tx_dout, P_SYNC);

        // Transport escape: SYNC until the remote answers SYNC
        start_to_data(8);
        sync_escape = 1'b1;
        tick();
        sync_escape = 1'b0;
        begin
            int s0;
            s0 = strobes;
            repeat (4) tick();
            check_eq("esc_no_strobe", strobes, s0);
            check_eq("esc_tx", tx_dout, P_SYNC);
            check_eq("esc_not_idle", idle, 0);
        end
        detect_sync = 1'b1;
        tick();
        detect_sync = 1'b0;
        check_eq("esc_idle", idle, 1);
        check_eq("esc_no_abort", abort_cnt, 0);

        // Asynchronous reset mid-frame
        start_to_data(8);
        #2 rst_n = 1'b0;
        #1;
        check_eq("rstmid_idle", idle, 1);
        check_eq("rstmid_tx", tx_dout, P_SYNC);
        check_eq("rstmid_k", tx_is_k, 1);
        check_eq("rstmid_strobe", wr.write_strobe, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_frame(5, 1'b1, 1, 1'b1, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
